// File: rtl/core_pipe_pkg.sv
// Shared pipeline definitions: control-bit indices, field widths and the data-vector layout
// used when packing and unpacking bundles at each stage boundary.
package core_pipe_pkg;

   localparam int unsigned CTRL_W      = 7;
   localparam int unsigned CTRL_WREGEN = 0;
   localparam int unsigned CTRL_WMEMEN = 1;
   localparam int unsigned CTRL_MEM2REG = 2;
   localparam int unsigned CTRL_RS2SW  = 3;
   localparam int unsigned CTRL_JAL    = 4;
   localparam int unsigned CTRL_JALR   = 5;
   localparam int unsigned CTRL_BR     = 6;

   localparam int unsigned XLEN = 64;
   localparam int unsigned PC_W = 8;
   localparam int unsigned RD_W = 5;
   localparam int unsigned F3_W = 3;
   localparam int unsigned F7_W = 1;

   localparam int unsigned DATA_W = 216;

   // Field offsets, LSB first; bits above OFF_SPARE are reserved
   localparam int unsigned OFF_RS1   = 0;
   localparam int unsigned OFF_RS2   = OFF_RS1 + XLEN;
   localparam int unsigned OFF_IMM   = OFF_RS2 + XLEN;
   localparam int unsigned OFF_RD    = OFF_IMM + XLEN;
   localparam int unsigned OFF_F3    = OFF_RD + RD_W;
   localparam int unsigned OFF_F7    = OFF_F3 + F3_W;
   localparam int unsigned OFF_PC    = OFF_F7 + F7_W;
   localparam int unsigned OFF_SPARE = OFF_PC + PC_W;
   localparam int unsigned SPARE_W   = DATA_W - OFF_SPARE;

   typedef logic [CTRL_W-1:0] ctrl_t;

   typedef struct packed {
      logic [SPARE_W-1:0] spare;
      logic [PC_W-1:0]    pc;
      logic [F7_W-1:0]    f7;
      logic [F3_W-1:0]    f3;
      logic [RD_W-1:0]    rd;
      logic [XLEN-1:0]    imm;
      logic [XLEN-1:0]    rs2;
      logic [XLEN-1:0]    rs1;
   } stage_data_t;

endpackage

// File: rtl/pipe_stage_hs_if.sv
// Valid/ready bundle channel between two pipeline stages.
interface pipe_stage_hs_if #(
   parameter int unsigned CTRL_W = core_pipe_pkg::CTRL_W,
   parameter int unsigned DATA_W = core_pipe_pkg::DATA_W
);

   logic              valid;
   logic              ready;
   logic [CTRL_W-1:0] ctrl;
   logic [DATA_W-1:0] data;

   modport master (output valid, output ctrl, output data, input ready);
   modport slave  (input valid, input ctrl, input data, output ready);

endinterface

// File: rtl/pipe_slot.sv
// One bundle register: valid bit plus control and data, with clear (bubble) and load enables.
module pipe_slot #(
   parameter int unsigned CTRL_W = 7,
   parameter int unsigned DATA_W = 216
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              load,
   input  logic              clear,
   input  logic [CTRL_W-1:0] d_ctrl,
   input  logic [DATA_W-1:0] d_data,
   output logic              valid,
   output logic [CTRL_W-1:0] ctrl,
   output logic [DATA_W-1:0] data
);

   // Clear zeroes ctrl so no enable survives in a bubble; data keeps its last value
   always_ff @(posedge CLK) begin
      if (RST) begin
         valid <= 1'b0;
         ctrl  <= '0;
         data  <= '0;
      end else if (clear) begin
         valid <= 1'b0;
         ctrl  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         ctrl  <= d_ctrl;
         data  <= d_data;
      end
   end

endmodule

// File: rtl/pipe_stage_hs.sv
// Handshaked pipeline stage register with a one-entry skid buffer, flush-to-bubble
// and a saturating downstream-stall counter.
module pipe_stage_hs #(
   parameter int unsigned CTRL_W = core_pipe_pkg::CTRL_W,
   parameter int unsigned DATA_W = core_pipe_pkg::DATA_W,
   parameter int unsigned CNT_W  = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             flush,
   pipe_stage_hs_if.slave   up,
   pipe_stage_hs_if.master  dn,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              main_valid, skid_valid;
   logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
   logic [DATA_W-1:0] main_data, skid_data;

   logic              accept_c, advance_c;
   logic              main_load_c, main_clear_c;
   logic              skid_load_c, skid_clear_c;
   logic [CTRL_W-1:0] main_d_ctrl_c;
   logic [DATA_W-1:0] main_d_data_c;

   // Ready depends only on the skid flag and reset, never on the input side
   assign up.ready = !skid_valid && !RST;

   // Steering: main advances when empty or drained; skid catches the one extra accept
   always_comb begin
      accept_c      = up.valid && up.ready;
      advance_c     = !main_valid || dn.ready;
      main_load_c   = !flush && advance_c && (skid_valid || accept_c);
      main_clear_c  = flush || (advance_c && !skid_valid && !accept_c);
      skid_load_c   = !flush && !advance_c && accept_c;
      skid_clear_c  = flush || (skid_valid && advance_c);
      main_d_ctrl_c = skid_valid ? skid_ctrl : up.ctrl;
      main_d_data_c = skid_valid ? skid_data : up.data;
   end

   pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
      .CLK    (CLK),
      .RST    (RST),
      .load   (main_load_c),
      .clear  (main_clear_c),
      .d_ctrl (main_d_ctrl_c),
      .d_data (main_d_data_c),
      .valid  (main_valid),
      .ctrl   (main_ctrl),
      .data   (main_data)
   );

   pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
      .CLK    (CLK),
      .RST    (RST),
      .load   (skid_load_c),
      .clear  (skid_clear_c),
      .d_ctrl (up.ctrl),
      .d_data (up.data),
      .valid  (skid_valid),
      .ctrl   (skid_ctrl),
      .data   (skid_data)
   );

   assign dn.valid = main_valid;
   assign dn.ctrl  = main_ctrl;
   assign dn.data  = main_data;

   // Counts stalled cycles; a flush cycle is not a stall
   always_ff @(posedge CLK) begin
      if (RST) begin
         stall_cnt <= '0;
      end else if (main_valid && !dn.ready && !flush && (stall_cnt != CNT_MAX)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed bench for pipe_stage_hs: scoreboard queue filled on accepted inputs and
// drained on downstream transfers, plus directed checks of reset, flush and saturation.
module tb_pipe_stage_hs;
   import core_pipe_pkg::*;

   localparam int unsigned CW = CTRL_W;
   localparam int unsigned DW = DATA_W;
   localparam int unsigned BW = CW + DW;

   logic        CLK = 1'b0;
   logic        RST;
   logic        flush;
   logic        flush2;
   logic [15:0] stall_cnt;
   logic [3:0]  stall_cnt2;

   always #5 CLK = ~CLK;

   pipe_stage_hs_if #(.CTRL_W(CW), .DATA_W(DW)) up_if ();
   pipe_stage_hs_if #(.CTRL_W(CW), .DATA_W(DW)) dn_if ();
   pipe_stage_hs_if #(.CTRL_W(CW), .DATA_W(DW)) up2_if ();
   pipe_stage_hs_if #(.CTRL_W(CW), .DATA_W(DW)) dn2_if ();

   pipe_stage_hs #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(16)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .flush     (flush),
      .up        (up_if.slave),
      .dn        (dn_if.master),
      .stall_cnt (stall_cnt)
   );

   pipe_stage_hs #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(4)) dut_sat (
      .CLK       (CLK),
      .RST       (RST),
      .flush     (flush2),
      .up        (up2_if.slave),
      .dn        (dn2_if.master),
      .stall_cnt (stall_cnt2)
   );

   logic [BW-1:0] sb_q[$];
   int            n_cmp = 0;
   int            n_err = 0;
   int            n_pop = 0;
   logic          last_in_fire = 1'b0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                        input logic ordy, input logic fl);
      up_if.valid = v;
      up_if.ctrl  = c;
      up_if.data  = d;
      dn_if.ready = ordy;
      flush       = fl;
   endtask

   // One clock: sample handshakes before the edge, update scoreboard, return at next negedge
   task automatic tick();
      logic          in_fire, out_fire;
      logic [BW-1:0] got;
      #1;
      in_fire  = up_if.valid && up_if.ready;
      out_fire = dn_if.valid && dn_if.ready;
      got      = {dn_if.ctrl, dn_if.data};
      last_in_fire = in_fire;
      if (RST) begin
         sb_q.delete();
      end else begin
         if (!dn_if.valid) chk("bubble_ctrl", 256'(dn_if.ctrl), 256'(0));
         if (out_fire) begin
            n_pop++;
            chk("sb_has_entry", 256'(sb_q.size() != 0), 256'(1));
            if (sb_q.size() != 0) chk("out_bundle", 256'(got), 256'(sb_q.pop_front()));
         end
         if (in_fire) sb_q.push_back({up_if.ctrl, up_if.data});
         if (flush) sb_q.delete();
      end
      @(negedge CLK);
   endtask

   function automatic logic [DW-1:0] mk_data(input logic [7:0] tag);
      stage_data_t s;
      s       = '0;
      s.rs1   = {8{tag}};
      s.rs2   = {8{~tag}};
      s.imm   = 64'(tag) << 12;
      s.rd    = tag[4:0];
      s.f3    = tag[2:0];
      s.f7    = tag[0];
      s.pc    = tag;
      return DW'(s);
   endfunction

   initial begin
      int pop0;
      int nxt;
      int stall_acc;

      RST          = 1'b1;
      flush2       = 1'b0;
      up2_if.valid = 1'b0;
      up2_if.ctrl  = '0;
      up2_if.data  = '0;
      dn2_if.ready = 1'b1;
      drive(1'b1, '1, '1, 1'b0, 1'b0);
      @(negedge CLK);

      // Reset held three cycles with in_valid asserted
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_in_ready", 256'(up_if.ready), 256'(0));
         chk("rst_out_valid", 256'(dn_if.valid), 256'(0));
         chk("rst_out_ctrl", 256'(dn_if.ctrl), 256'(0));
         chk("rst_stall_cnt", 256'(stall_cnt), 256'(0));
      end
      chk("rst_out_data", 256'(dn_if.data), 256'(0));
      RST = 1'b0;
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      #1;
      chk("rst_release_ready", 256'(up_if.ready), 256'(1));

      // Streaming 1..8 with downstream always ready
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, CW'(i), DW'(i), 1'b1, 1'b0);
         tick();
         chk("stream_accept", 256'(last_in_fire), 256'(1));
         chk("stream_valid", 256'(dn_if.valid), 256'(1));
         chk("stream_data", 256'(dn_if.data), 256'(i));
      end
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      tick();
      chk("stream_drained", 256'(dn_if.valid), 256'(0));
      chk("stream_hold_data", 256'(dn_if.data), 256'(8));
      chk("stream_stall_cnt", 256'(stall_cnt), 256'(0));

      // Backpressure: out_ready low for cycles 3..5
      pop0      = n_pop;
      nxt       = 1;
      stall_acc = 0;
      for (int c = 0; c < 20; c++) begin
         logic ordy;
         ordy = !(c >= 3 && c <= 5);
         if (c == 4 || c == 5) chk("bp_in_ready_low", 256'(up_if.ready), 256'(0));
         drive(nxt <= 8, CW'(nxt + 16), DW'(nxt), ordy, 1'b0);
         tick();
         if (last_in_fire) begin
            if (!ordy) stall_acc++;
            nxt++;
         end
      end
      chk("bp_extra_accepts", 256'(stall_acc), 256'(1));
      chk("bp_stall_cnt", 256'(stall_cnt), 256'(3));
      chk("bp_all_accepted", 256'(nxt), 256'(9));
      chk("bp_delivered", 256'(n_pop - pop0), 256'(8));
      chk("bp_sb_empty", 256'(sb_q.size()), 256'(0));

      // Flush while main=A, skid=B and C offered
      pop0 = n_pop;
      drive(1'b1, CW'(1 << CTRL_WREGEN) | CW'(1 << CTRL_WMEMEN), mk_data(8'hA1), 1'b0, 1'b0);
      tick();
      drive(1'b1, CW'(1 << CTRL_BR) | CW'(1 << CTRL_JAL), mk_data(8'hB2), 1'b0, 1'b0);
      tick();
      chk("fl_skid_full", 256'(up_if.ready), 256'(0));
      drive(1'b1, CW'(1 << CTRL_JALR) | CW'(1 << CTRL_MEM2REG) | CW'(1 << CTRL_RS2SW),
            mk_data(8'hC3), 1'b0, 1'b1);
      tick();
      chk("fl_out_valid", 256'(dn_if.valid), 256'(0));
      chk("fl_out_ctrl", 256'(dn_if.ctrl), 256'(0));
      chk("fl_in_ready", 256'(up_if.ready), 256'(1));
      chk("fl_stall_cnt", 256'(stall_cnt), 256'(4));
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) tick();
      chk("fl_no_leak", 256'(n_pop - pop0), 256'(0));

      // Flush while downstream takes the current bundle
      pop0 = n_pop;
      drive(1'b1, CW'(1 << CTRL_WREGEN), mk_data(8'hD4), 1'b1, 1'b0);
      tick();
      chk("fd_valid", 256'(dn_if.valid), 256'(1));
      chk("fd_pc_field", 256'(dn_if.data[OFF_PC +: PC_W]), 256'(8'hD4));
      drive(1'b1, CW'(1 << CTRL_BR), mk_data(8'hE5), 1'b1, 1'b1);
      tick();
      chk("fd_delivered_once", 256'(n_pop - pop0), 256'(1));
      chk("fd_out_valid", 256'(dn_if.valid), 256'(0));
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) tick();
      chk("fd_no_dup", 256'(n_pop - pop0), 256'(1));

      // Simultaneous flush and reset with both slots full
      drive(1'b1, CW'(1 << CTRL_JAL), mk_data(8'hF6), 1'b0, 1'b0);
      tick();
      drive(1'b1, CW'(1 << CTRL_JALR), mk_data(8'h17), 1'b0, 1'b0);
      tick();
      chk("rf_pre_stall", 256'(stall_cnt), 256'(5));
      RST = 1'b1;
      drive(1'b1, CW'(1 << CTRL_WMEMEN), mk_data(8'h28), 1'b1, 1'b1);
      tick();
      chk("rf_out_valid", 256'(dn_if.valid), 256'(0));
      chk("rf_out_ctrl", 256'(dn_if.ctrl), 256'(0));
      chk("rf_out_data", 256'(dn_if.data), 256'(0));
      chk("rf_stall_cnt", 256'(stall_cnt), 256'(0));
      chk("rf_in_ready", 256'(up_if.ready), 256'(0));
      RST  = 1'b0;
      pop0 = n_pop;
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      #1;
      chk("rf_release_ready", 256'(up_if.ready), 256'(1));
      for (int i = 0; i < 3; i++) tick();
      chk("rf_nothing_left", 256'(n_pop - pop0), 256'(0));

      // Saturation on the 4-bit counter instance
      up2_if.valid = 1'b1;
      up2_if.ctrl  = CW'(1 << CTRL_WREGEN);
      up2_if.data  = mk_data(8'h39);
      dn2_if.ready = 1'b0;
      tick();
      up2_if.valid = 1'b0;
      for (int i = 0; i < 14; i++) tick();
      chk("sat_14", 256'(stall_cnt2), 256'(14));
      tick();
      chk("sat_15", 256'(stall_cnt2), 256'(15));
      for (int i = 0; i < 5; i++) tick();
      chk("sat_hold", 256'(stall_cnt2), 256'(15));
      chk("sat_data_held", 256'(dn2_if.data), 256'(mk_data(8'h39)));
      chk("sat_valid_held", 256'(dn2_if.valid), 256'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
